// File: rtl/sdr_upload_reader_if.sv
// Bundles the start/parameter inputs, the toggle req/ack SDRAM read port and
// the ioctl-style byte output of the upload reader.
interface sdr_upload_reader_if #(
  parameter int ADDR_W = 25
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] byte_count;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] sdr_addr;
  logic              sdr_req;
  logic              sdr_ack;
  logic [15:0]       sdr_data;
  logic [ADDR_W-1:0] out_addr;
  logic [7:0]        out_data;
  logic              out_wr;
  logic              out_wait;

  // The reader itself: issues SDRAM requests and drives the byte stream.
  modport master (
    input  start, base_addr, byte_count, sdr_ack, sdr_data, out_wait,
    output busy, done, sdr_addr, sdr_req, out_addr, out_data, out_wr
  );

  // The surroundings: controller, SDRAM port and byte sink.
  modport slave (
    output start, base_addr, byte_count, sdr_ack, sdr_data, out_wait,
    input  busy, done, sdr_addr, sdr_req, out_addr, out_data, out_wr
  );
endinterface

// File: rtl/sdr_upload_reader.sv
// Reads a byte range back out of SDRAM over a toggle req/ack port and emits
// it as an ioctl-style byte stream, two bytes per 16-bit word, with an
// optional one-word prefetch to hide SDRAM latency behind byte emission.
module sdr_upload_reader #(
  parameter int ADDR_W   = 25,
  parameter bit PREFETCH = 1'b1
) (
  input logic                 clk_sys,
  input logic                 reset_n,
  sdr_upload_reader_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, EMIT_LO, EMIT_HI, FIN} state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-1){1'b1}}, 1'b0};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic [ADDR_W-1:0] sdr_addr_q, sdr_addr_d;
  logic              sdr_req_q, sdr_req_d;
  logic              pend_q, pend_d;       // a request is in flight
  logic [15:0]       word_q, word_d;       // word currently being emitted
  logic [15:0]       pf_q, pf_d;           // prefetched next word
  logic              pf_valid_q, pf_valid_d;

  logic              rx;
  logic              emit;
  logic              accept;
  logic              want_pf;
  logic              issue;
  logic [ADDR_W-1:0] held;

  // State register; async reset abandons any in-flight read (controller resets too).
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      remain_q   <= '0;
      off_q      <= '0;
      sdr_addr_q <= '0;
      sdr_req_q  <= 1'b0;
      pend_q     <= 1'b0;
      word_q     <= '0;
      pf_q       <= '0;
      pf_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      remain_q   <= remain_d;
      off_q      <= off_d;
      sdr_addr_q <= sdr_addr_d;
      sdr_req_q  <= sdr_req_d;
      pend_q     <= pend_d;
      word_q     <= word_d;
      pf_q       <= pf_d;
      pf_valid_q <= pf_valid_d;
    end
  end

  // Next-state logic: request issue, word capture/prefetch and byte emission.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    remain_d   = remain_q;
    off_d      = off_q;
    sdr_addr_d = sdr_addr_q;
    sdr_req_d  = sdr_req_q;
    pend_d     = pend_q;
    word_d     = word_q;
    pf_d       = pf_q;
    pf_valid_d = pf_valid_q;
    issue      = 1'b0;

    rx     = pend_q && (sdr_req_q == bus.sdr_ack);
    emit   = (state_q == EMIT_LO) || (state_q == EMIT_HI);
    accept = emit && !bus.out_wait;
    // Bytes of the current word not yet emitted; the prefetch slot is empty
    // whenever this is consulted.
    held    = (state_q == EMIT_LO) ? ADDR_W'(2) : ADDR_W'(1);
    want_pf = PREFETCH && emit && !pend_q && !pf_valid_q && (remain_q > held);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rd_ptr_d   = bus.base_addr & ALIGN_MASK;
          remain_d   = bus.byte_count;
          off_d      = '0;
          pf_valid_d = 1'b0;
          if (bus.byte_count == '0) begin
            state_d = FIN;
          end else begin
            issue   = 1'b1;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (rx) begin
          word_d  = bus.sdr_data;
          pend_d  = 1'b0;
          state_d = EMIT_LO;
        end
      end
      EMIT_LO, EMIT_HI: begin
        // Data landing while emitting goes to the prefetch slot by default.
        if (rx) begin
          pf_d       = bus.sdr_data;
          pf_valid_d = 1'b1;
          pend_d     = 1'b0;
        end
        issue = want_pf;
        if (accept) begin
          remain_d = remain_q - ADDR_W'(1);
          off_d    = off_q + ADDR_W'(1);
          if (remain_q == ADDR_W'(1)) begin
            // Last byte (an odd count drops the high byte); any spare word is discarded.
            pf_valid_d = 1'b0;
            state_d    = FIN;
          end else if (state_q == EMIT_LO) begin
            state_d = EMIT_HI;
          end else if (pf_valid_q) begin
            word_d     = pf_q;
            pf_valid_d = 1'b0;
            state_d    = EMIT_LO;
          end else if (rx) begin
            word_d     = bus.sdr_data;
            pf_valid_d = 1'b0;
            state_d    = EMIT_LO;
          end else begin
            issue   = issue || !pend_q;
            state_d = FETCH;
          end
        end
      end
      FIN: begin
        // Drain an unused read before signalling completion.
        if (rx) begin
          pend_d = 1'b0;
        end
        if (!pend_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      sdr_addr_d = rd_ptr_d;
      rd_ptr_d   = rd_ptr_d + ADDR_W'(2);
      sdr_req_d  = ~sdr_req_q;
      pend_d     = 1'b1;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == FIN) && !pend_q;
  assign bus.out_wr   = accept;
  assign bus.out_data = (state_q == EMIT_HI) ? word_q[15:8] : word_q[7:0];
  assign bus.out_addr = off_q;
  assign bus.sdr_addr = sdr_addr_q;
  assign bus.sdr_req  = sdr_req_q;
endmodule

// File: tb/tb_sdr_upload_reader.sv
// Directed bench for sdr_upload_reader: table of transfers plus hand-written
// sequences for zero-length, mid-transfer start and asynchronous reset.
module tb_sdr_upload_reader;
  localparam int AW = 25;
  localparam logic [AW-1:0] ALIGN = {{(AW-1){1'b1}}, 1'b0};

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;

  sdr_upload_reader_if #(.ADDR_W(AW)) bus ();

  sdr_upload_reader #(.ADDR_W(AW), .PREFETCH(1'b1)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM content: byte at address a is ((a[7:0]+1)*0x11) mod 256.
  function automatic logic [7:0] bval(input logic [AW-1:0] a);
    logic [7:0] t;
    t = a[7:0] + 8'd1;
    return 8'(t * 8'h11);
  endfunction

  // SDRAM port model: answers each toggle two cycles after noticing it.
  int lat_cnt;
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bus.sdr_ack  <= 1'b0;
      bus.sdr_data <= '0;
      lat_cnt      <= 0;
    end else if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) begin
        bus.sdr_ack  <= bus.sdr_req;
        bus.sdr_data <= {bval(bus.sdr_addr | AW'(1)), bval(bus.sdr_addr & ALIGN)};
      end
    end else if (bus.sdr_req != bus.sdr_ack) begin
      lat_cnt <= 2;
    end
  end

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] cnt;
    int            stall_after;
    int            stall_len;
    int            mid_start;
    int            exp_reqs;
    logic [7:0]    exp_first;
    logic [7:0]    exp_last;
  } vec_t;

  vec_t vecs[8];
  vec_t rst_vec;

  int passed = 0;
  int total  = 0;
  string cur_tag = "";

  logic [7:0]    got_data[$];
  logic [AW-1:0] got_addr[$];
  int n_req, n_ack, n_done, n_busy, viol, fviol, wr_last, done_cycle, timeout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s %s: got %0h expected %0h", cur_tag, name, act, exp);
  endtask

  // Start one transfer and observe it, cycle by cycle, until done plus a short tail.
  task automatic run_xfer(input logic [AW-1:0] base, input logic [AW-1:0] cnt,
                          input int stall_after, input int stall_len, input int mid_start);
    logic prev_req, prev_ack;
    int   stall_left, tail;
    bit   stalled, fin;
    got_data.delete();
    got_addr.delete();
    n_req = 0; n_ack = 0; n_done = 0; n_busy = 0; viol = 0; fviol = 0;
    wr_last = -1; done_cycle = -1; timeout = 0;
    stall_left = stall_len; stalled = 1'b0; fin = 1'b0; tail = 0;
    prev_req = bus.sdr_req;
    prev_ack = bus.sdr_ack;
    @(negedge clk_sys);
    bus.start = 1'b1; bus.base_addr = base; bus.byte_count = cnt;
    @(negedge clk_sys);
    for (int c = 0; c < 2000 && tail < 3; c++) begin
      bus.start = (c == mid_start);
      if (c == mid_start) begin
        bus.base_addr  = AW'(25'h800);
        bus.byte_count = AW'(2);
      end
      if (!stalled && stall_len > 0 && got_data.size() == stall_after) stalled = 1'b1;
      if (stalled && stall_left > 0) begin
        bus.out_wait = 1'b1;
        stall_left--;
      end else begin
        bus.out_wait = 1'b0;
      end
      #1;
      if (bus.sdr_req != prev_req) n_req++;
      if (bus.sdr_ack != prev_ack) n_ack++;
      prev_req = bus.sdr_req;
      prev_ack = bus.sdr_ack;
      if (n_req - n_ack > 1 || n_req < n_ack) viol++;
      if (bus.out_wr && (bus.done || !bus.busy || bus.out_wait)) viol++;
      if (bus.busy) n_busy++;
      if (bus.out_wait) begin
        if (bus.out_addr != AW'(stall_after)) fviol++;
        if (stall_left < 5 && bus.out_data != bval((base & ALIGN) + AW'(stall_after))) fviol++;
      end
      if (bus.out_wr) begin
        got_data.push_back(bus.out_data);
        got_addr.push_back(bus.out_addr);
        wr_last = c;
      end
      if (bus.done) begin
        n_done++;
        if (!fin) begin
          fin = 1'b1;
          done_cycle = c;
        end
      end
      if (fin) tail++;
      @(negedge clk_sys);
    end
    bus.out_wait = 1'b0;
    bus.start    = 1'b0;
    if (!fin) timeout = 1;
    $display("xfer base=%h count=%0d bytes=%0d reqs=%0d done_at=%0d",
             base, cnt, got_data.size(), n_req, done_cycle);
  endtask

  task automatic check_vec(input vec_t v);
    int mism;
    logic [AW-1:0] al;
    mism = 0;
    al = v.base & ALIGN;
    chk("timeout", timeout, 0);
    chk("nbytes", got_data.size(), v.cnt);
    for (int i = 0; i < got_data.size(); i++) begin
      if (got_addr[i] != AW'(i) || got_data[i] != bval(al + AW'(i))) mism++;
    end
    chk("stream", mism, 0);
    chk("first", (got_data.size() > 0) ? got_data[0] : 8'h00, v.exp_first);
    chk("last", (got_data.size() > 0) ? got_data[got_data.size()-1] : 8'h00, v.exp_last);
    chk("reqs", n_req, v.exp_reqs);
    chk("acks", n_ack, v.exp_reqs);
    chk("done_pulses", n_done, 1);
    chk("done_lat", done_cycle, wr_last + 1);
    chk("protocol", viol, 0);
    if (v.stall_len > 0) chk("freeze", fviol, 0);
    chk("busy_after", bus.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{25'h100,     25'd4, 0, 0,  -1, 2, 8'h11, 8'h44};
    vecs[1] = '{25'h100,     25'd3, 0, 0,  -1, 2, 8'h11, 8'h33};
    vecs[2] = '{25'h101,     25'd4, 0, 0,  -1, 2, 8'h11, 8'h44};
    vecs[3] = '{25'h100,     25'd8, 2, 10, -1, 4, 8'h11, 8'h88};
    vecs[4] = '{25'h1FFFFFE, 25'd4, 0, 0,  -1, 2, 8'hEF, 8'h22};
    vecs[5] = '{25'h100,     25'd1, 0, 0,  -1, 1, 8'h11, 8'h11};
    vecs[6] = '{25'h200,     25'd5, 3, 3,  -1, 3, 8'h11, 8'h55};
    vecs[7] = '{25'h100,     25'd6, 0, 0,  3,  3, 8'h11, 8'h66};
    rst_vec = '{25'h100,    25'd16, 0, 0,  -1, 8, 8'h11, 8'h10};

    bus.start = 1'b0; bus.base_addr = '0; bus.byte_count = '0; bus.out_wait = 1'b0;

    // Reset state
    cur_tag = "reset";
    repeat (3) @(negedge clk_sys);
    chk("busy", bus.busy, 0);
    chk("done", bus.done, 0);
    chk("sdr_req", bus.sdr_req, 0);
    chk("sdr_addr", bus.sdr_addr, 0);
    chk("out_addr", bus.out_addr, 0);
    chk("out_data", bus.out_data, 0);
    chk("out_wr", bus.out_wr, 0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    for (int k = 0; k < 8; k++) begin
      cur_tag = $sformatf("vec%0d", k);
      run_xfer(vecs[k].base, vecs[k].cnt, vecs[k].stall_after, vecs[k].stall_len, vecs[k].mid_start);
      check_vec(vecs[k]);
    end

    // Zero-length transfer: no SDRAM access, immediate done
    cur_tag = "zero";
    run_xfer(25'h300, 25'd0, 0, 0, -1);
    chk("timeout", timeout, 0);
    chk("reqs", n_req, 0);
    chk("nbytes", got_data.size(), 0);
    chk("done_within_2", (done_cycle >= 0 && done_cycle <= 1), 1'b1);
    chk("busy_cycles_le1", (n_busy <= 1), 1'b1);
    chk("done_pulses", n_done, 1);

    // Asynchronous reset while waiting on the first word of a 16-byte read
    cur_tag = "async_reset";
    @(negedge clk_sys);
    bus.start = 1'b1; bus.base_addr = 25'h100; bus.byte_count = 25'd16;
    @(negedge clk_sys);
    bus.start = 1'b0;
    #1;
    chk("busy_before", bus.busy, 1'b1);
    chk("req_outstanding", (bus.sdr_req != bus.sdr_ack), 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("busy", bus.busy, 0);
    chk("out_wr", bus.out_wr, 0);
    chk("sdr_req", bus.sdr_req, 0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    cur_tag = "after_reset";
    run_xfer(rst_vec.base, rst_vec.cnt, 0, 0, -1);
    check_vec(rst_vec);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
